rcu: RTL and testbench

//  Receiver control unit: sequences the UART receiver datapath around the bit timer.

---
 rtl/rcu_pkg.sv | 7 +
 rtl/rcu_err_counter.sv | 16 +
 rtl/rcu.sv | 58 +++++
 tb/tb_rcu.sv | 121 ++++++++++++
 4 files changed

// File: rtl/rcu_pkg.sv
// rcu_pkg: receiver control unit state encoding and frame geometry shared with the bit timer
`timescale 1ns/100ps
package rcu_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, RECEIVE, STOP_CHK, STOP_WAIT, LOAD} rcu_state_t;
  localparam int DATA_BITS = 8;
  localparam int FRAME_BITS = 9;
endpackage

// File: rtl/rcu_err_counter.sv
// rcu_err_counter: saturating framing-error counter, cleared only by n_rst
`timescale 1ns/100ps
module rcu_err_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) r_count <= '0;
    else if (i_inc && r_count != '1) r_count <= r_count + 1'b1;
  assign o_count = r_count;
endmodule

// File: rtl/rcu.sv
// rcu: UART receiver control FSM sequencing timer, stop-bit checker and RX buffer load.
// Define RCU_ERR_CNT_EN to add the saturating err_count output.
`timescale 1ns/100ps
module rcu
  import rcu_pkg::*;
`ifdef RCU_ERR_CNT_EN
#(
  parameter int ERR_CNT_BITS = 4
)
`endif
(
  input  logic clk,
  input  logic n_rst,
  input  logic start_bit_detected,
  input  logic packet_done,
  input  logic framing_error,
  output logic sbc_clear,
  output logic sbc_enable,
  output logic load_buffer,
  output logic enable_timer
`ifdef RCU_ERR_CNT_EN
  ,
  output logic [ERR_CNT_BITS-1:0] err_count
`endif
);
  rcu_state_t r_state, w_next;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) r_state <= IDLE;
    else r_state <= w_next;
  // Moore decode: outputs depend on r_state only; stray encodings fall back to IDLE
  always_comb begin
    w_next = IDLE;
    sbc_clear = 1'b0;
    sbc_enable = 1'b0;
    load_buffer = 1'b0;
    enable_timer = 1'b0;
    case (r_state)
      IDLE:      w_next = start_bit_detected ? CLEAR : IDLE;
      CLEAR:     begin sbc_clear = 1'b1; w_next = RECEIVE; end
      RECEIVE:   begin enable_timer = 1'b1; w_next = packet_done ? STOP_CHK : RECEIVE; end
      STOP_CHK:  begin sbc_enable = 1'b1; w_next = STOP_WAIT; end
      STOP_WAIT: w_next = framing_error ? IDLE : LOAD;
      LOAD:      begin load_buffer = 1'b1; w_next = IDLE; end
      default:   w_next = IDLE;
    endcase
  end
`ifdef RCU_ERR_CNT_EN
  logic w_err_inc;
  assign w_err_inc = (r_state == STOP_WAIT) && framing_error;
  rcu_err_counter #(.W(ERR_CNT_BITS)) u_err_counter (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_inc  (w_err_inc),
    .o_count(err_count)
  );
`else
`endif
endmodule

// File: tb/tb_rcu.sv
// tb_rcu: directed-vector scoreboard bench for rcu; expected outputs queued per cycle
`timescale 1ns/100ps
module tb_rcu;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start_bit_detected = 1'b0;
  logic packet_done = 1'b0;
  logic framing_error = 1'b0;
  logic sbc_clear, sbc_enable, load_buffer, enable_timer;
  logic [3:0] err_count;
  logic [3:0] n_bad = 4'd0;
  logic [7:0] q[$];
  int checks = 0;
  int errors = 0;

  always #1.25 clk = ~clk;

  rcu dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .start_bit_detected(start_bit_detected),
    .packet_done       (packet_done),
    .framing_error     (framing_error),
    .sbc_clear         (sbc_clear),
    .sbc_enable        (sbc_enable),
    .load_buffer       (load_buffer),
    .enable_timer      (enable_timer)
`ifdef RCU_ERR_CNT_EN
    ,
    .err_count         (err_count)
`endif
  );
`ifndef RCU_ERR_CNT_EN
  assign err_count = 4'd0;
`endif

  // outs vector: {sbc_clear, enable_timer, sbc_enable, load_buffer}
  always @(negedge clk) begin
    if (q.size() != 0) begin
      logic [7:0] it;
      it = q.pop_front();
      checks++;
      if ({sbc_clear, enable_timer, sbc_enable, load_buffer} !== it[3:0]) begin
        errors++;
        $display("FAIL outs @%0t got %b exp %b", $time,
                 {sbc_clear, enable_timer, sbc_enable, load_buffer}, it[3:0]);
      end
`ifdef RCU_ERR_CNT_EN
      checks++;
      if (err_count !== it[7:4]) begin
        errors++;
        $display("FAIL err_count @%0t got %0d exp %0d", $time, err_count, it[7:4]);
      end
`endif
    end
  end

  task automatic cyc(input logic sb, input logic pd, input logic fe, input logic [3:0] ex);
    start_bit_detected = sb;
    packet_done = pd;
    framing_error = fe;
    q.push_back({n_bad, ex});
    @(negedge clk);
    #0.1;
  endtask

  task automatic frame(input int n_rx, input logic bad, input logic noise);
    cyc(1, 0, 0, 4'b1000);
    cyc(0, 0, 0, 4'b0100);
    repeat (n_rx) cyc(noise, 0, 0, 4'b0100);
    cyc(0, 1, 0, 4'b0010);
    cyc(0, 0, noise, 4'b0000);
    if (bad) n_bad = (n_bad == 4'hF) ? 4'hF : n_bad + 4'd1;
    cyc(0, 0, bad, bad ? 4'b0000 : 4'b0001);
  endtask

  initial begin
    @(negedge clk);
    #0.1;
    cyc(0, 0, 0, 4'b0000);
    n_rst = 1'b1;
    cyc(0, 0, 0, 4'b0000);
    cyc(0, 1, 1, 4'b0000);
    frame(3, 0, 0);
    cyc(0, 0, 0, 4'b0000);
    frame(2, 1, 0);
    cyc(0, 0, 0, 4'b0000);
    frame(3, 0, 1);
    cyc(1, 0, 0, 4'b0000);
    frame(1, 0, 0);
    cyc(0, 0, 0, 4'b0000);
    cyc(1, 0, 0, 4'b1000);
    cyc(0, 0, 0, 4'b0100);
    cyc(0, 0, 0, 4'b0100);
    n_rst = 1'b0;
    n_bad = 4'd0;
    #0.2;
    checks++;
    if ({sbc_clear, enable_timer, sbc_enable, load_buffer} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got %b exp 0000",
               {sbc_clear, enable_timer, sbc_enable, load_buffer});
    end
    #0.9;
    cyc(0, 1, 0, 4'b0000);
    n_rst = 1'b1;
    cyc(0, 0, 0, 4'b0000);
    cyc(0, 1, 0, 4'b0000);
    repeat (17) frame(0, 1, 0);
    cyc(0, 0, 0, 4'b0000);
    frame(1, 0, 0);
    cyc(0, 0, 0, 4'b0000);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
